reset_sequencer: RTL and testbench

//  Power-on and reset sequencer for the CLK_25 domain, directly downstream of the MMCM clock generator.

---
 rtl/reset_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Power-on / reset sequencer for the CLK_25 domain. Synchronises the board
//   reset, then releases camera power-down, camera reset and core reset in a
//   timed order, launches sensor configuration with a one-cycle CFG_START
//   pulse and supervises completion with a timeout and a bounded retry count.
//
//   Optional feature macro: RSTSEQ_LOCK_MON_EN
//     defined   : LOCKED input exists; losing lock restarts from S_STAB.
//     undefined : no LOCKED input; lock is treated as permanently good.
//
// Ports
//   CLK_25       in   the single clock
//   RST_N        in   asynchronous active-low reset
//   LOCKED       in   MMCM lock (only with RSTSEQ_LOCK_MON_EN)
//   CFG_DONE     in   configuration complete level, sampled only in S_WAIT
//   CAM_PWDN     out  camera power-down, active high
//   CAM_RESET_N  out  camera reset, active low
//   CORE_RST_N   out  active-low reset for datapath logic
//   CFG_START    out  one-cycle configuration start pulse
//   SYS_READY    out  configuration accepted
//   FAULT        out  configuration failed MAX_RETRY times (sticky)
//   STATE        out  current state code for debug
`timescale 1ns/1ps

module reset_sequencer #(
    parameter int unsigned STAB_CYC    = 2500,
    parameter int unsigned PWDN_CYC    = 25000,
    parameter int unsigned RST_CYC     = 25000,
    parameter int unsigned CFG_TIMEOUT = 2500000,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned CNT_W       = 22
) (
    input  logic       CLK_25,
    input  logic       RST_N,
`ifdef RSTSEQ_LOCK_MON_EN
    input  logic       LOCKED,
`endif
    input  logic       CFG_DONE,
    output logic       CAM_PWDN,
    output logic       CAM_RESET_N,
    output logic       CORE_RST_N,
    output logic       CFG_START,
    output logic       SYS_READY,
    output logic       FAULT,
    output logic [2:0] STATE
);

    localparam int unsigned RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STAB_CYC - 1);
    localparam logic [CNT_W-1:0] PWDN_LAST = CNT_W'(PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_LAST  = RTY_W'(MAX_RETRY - 1);

    // S_DONE doubles as the fault terminal; FAULT/SYS_READY tell them apart.
    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_STAB  = 3'd1,
        S_PWDN  = 3'd2,
        S_CRST  = 3'd3,
        S_CFG   = 3'd4,
        S_WAIT  = 3'd5,
        S_RETRY = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [RTY_W-1:0] retry;
    logic [1:0]       rst_sync;
    logic             rst_released;
    logic             lock_ok;

    assign STATE        = state;
    assign rst_released = rst_sync[1];

    always_ff @(posedge CLK_25 or negedge RST_N) begin
        if (!RST_N) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

`ifdef RSTSEQ_LOCK_MON_EN
    logic [1:0] lock_sync;

    always_ff @(posedge CLK_25 or negedge RST_N) begin
        if (!RST_N) begin
            lock_sync <= '0;
        end else begin
            lock_sync <= {lock_sync[0], LOCKED};
        end
    end

    assign lock_ok = lock_sync[1];
`else
    assign lock_ok = 1'b1;
`endif

    always_ff @(posedge CLK_25 or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_SYNC;
            cnt         <= '0;
            retry       <= '0;
            CAM_PWDN    <= 1'b1;
            CAM_RESET_N <= 1'b0;
            CORE_RST_N  <= 1'b0;
            CFG_START   <= 1'b0;
            SYS_READY   <= 1'b0;
            FAULT       <= 1'b0;
        end else if (!lock_ok && state != S_SYNC) begin
            // Lock loss (or lock not yet present) parks the sequence in
            // S_STAB with every output back at its reset value.
            state       <= S_STAB;
            cnt         <= '0;
            retry       <= '0;
            CAM_PWDN    <= 1'b1;
            CAM_RESET_N <= 1'b0;
            CORE_RST_N  <= 1'b0;
            CFG_START   <= 1'b0;
            SYS_READY   <= 1'b0;
            FAULT       <= 1'b0;
        end else begin
            cnt       <= cnt + 1'b1;
            CFG_START <= 1'b0;
            case (state)
                S_SYNC: begin
                    if (rst_released) begin
                        state <= S_STAB;
                        cnt   <= '0;
                    end
                end
                S_STAB: begin
                    if (cnt == STAB_LAST) begin
                        state    <= S_PWDN;
                        cnt      <= '0;
                        CAM_PWDN <= 1'b0;
                    end
                end
                S_PWDN: begin
                    if (cnt == PWDN_LAST) begin
                        state       <= S_CRST;
                        cnt         <= '0;
                        CAM_RESET_N <= 1'b1;
                    end
                end
                S_CRST: begin
                    if (cnt == RST_LAST) begin
                        state      <= S_CFG;
                        cnt        <= '0;
                        CORE_RST_N <= 1'b1;
                        CFG_START  <= 1'b1;
                    end
                end
                S_CFG: begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
                S_WAIT: begin
                    // Completion beats a coincident timeout.
                    if (CFG_DONE) begin
                        state     <= S_DONE;
                        SYS_READY <= 1'b1;
                    end else if (cnt == TMO_LAST) begin
                        retry <= retry + 1'b1;
                        cnt   <= '0;
                        if (retry < RTY_LAST) begin
                            state       <= S_RETRY;
                            CAM_RESET_N <= 1'b0;
                        end else begin
                            state <= S_DONE;
                            FAULT <= 1'b1;
                        end
                    end
                end
                S_RETRY: begin
                    if (cnt == RST_LAST) begin
                        state       <= S_CRST;
                        cnt         <= '0;
                        CAM_RESET_N <= 1'b1;
                    end
                end
                S_DONE: begin
                    cnt <= cnt;
                end
                default: begin
                    state <= S_SYNC;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Self-checking bench for reset_sequencer with short delay parameters.
//   Expected outputs come from an event timeline (edge numbers of each
//   milestone) built from the sequencing rules, not from a state machine.
//   Build with RSTSEQ_LOCK_MON_EN defined to also exercise lock loss.
`timescale 1ns/1ps

module tb_reset_sequencer;

    localparam int STAB = 4;
    localparam int PWDN = 8;
    localparam int RST  = 8;
    localparam int TMO  = 16;
    localparam int MAXR = 2;

    // {STATE, CAM_PWDN, CAM_RESET_N, CORE_RST_N, CFG_START, SYS_READY, FAULT}
    localparam logic [8:0] RESET_VAL = 9'b000_1_0_0_0_0_0;

    logic       clk;
    logic       clk_run;
    logic       rst_n;
    logic       locked;
    logic       cfg_done;
    logic       cam_pwdn;
    logic       cam_reset_n;
    logic       core_rst_n;
    logic       cfg_start;
    logic       sys_ready;
    logic       fault;
    logic [2:0] state;
    logic [8:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    reset_sequencer #(
        .STAB_CYC   (STAB),
        .PWDN_CYC   (PWDN),
        .RST_CYC    (RST),
        .CFG_TIMEOUT(TMO),
        .MAX_RETRY  (MAXR),
        .CNT_W      (22)
    ) dut (
        .CLK_25     (clk),
        .RST_N      (rst_n),
`ifdef RSTSEQ_LOCK_MON_EN
        .LOCKED     (locked),
`endif
        .CFG_DONE   (cfg_done),
        .CAM_PWDN   (cam_pwdn),
        .CAM_RESET_N(cam_reset_n),
        .CORE_RST_N (core_rst_n),
        .CFG_START  (cfg_start),
        .SYS_READY  (sys_ready),
        .FAULT      (fault),
        .STATE      (state)
    );

    assign outs = {state, cam_pwdn, cam_reset_n, core_rst_n, cfg_start, sys_ready, fault};

    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Timeline model: edge numbers (edge 0 = first edge after release).
    int m_stab, m_pf, m_cr, m_att, m_ready, m_fault;
    int m_crs[MAXR];
    int m_cfg[MAXR];
    int m_to [MAXR];

    task automatic build_model(input int stab_e, input int done_at);
        int crs, ws, s;
        m_stab  = stab_e;
        m_pf    = stab_e + STAB;
        m_cr    = m_pf + PWDN;
        m_att   = 0;
        m_ready = -1;
        m_fault = -1;
        crs     = m_cr;
        for (int k = 0; k < MAXR; k++) begin
            m_crs[k] = crs;
            m_cfg[k] = crs + RST;
            ws       = m_cfg[k] + 1;
            m_to[k]  = ws + TMO;
            m_att    = k + 1;
            if (done_at >= 0) begin
                // CFG_DONE level is first seen at an edge evaluated in S_WAIT.
                s = (done_at + 1 > ws + 1) ? done_at + 1 : ws + 1;
                if (s <= m_to[k]) begin
                    m_ready = s;
                    break;
                end
            end
            if (k + 1 < MAXR) crs = m_to[k] + RST;
            else              m_fault = m_to[k];
        end
    endtask

    function automatic int term_edge();
        return (m_ready >= 0) ? m_ready : m_fault;
    endfunction

    function automatic logic [8:0] model_out(input int n);
        logic [2:0] st;
        logic pw, cr, co, cs, rd, ft;
        pw = (n < m_pf);
        cr = (n >= m_cr);
        co = (n >= m_cfg[0]);
        cs = 1'b0;
        rd = (m_ready >= 0) && (n >= m_ready);
        ft = (m_fault >= 0) && (n >= m_fault);
        for (int k = 1; k < m_att; k++)
            if (n >= m_to[k-1] && n < m_crs[k]) cr = 1'b0;
        for (int k = 0; k < m_att; k++)
            if (n == m_cfg[k]) cs = 1'b1;
        st = 3'd0;
        if (n < m_stab)      st = 3'd0;
        else if (n < m_pf)   st = 3'd1;
        else if (n < m_cr)   st = 3'd2;
        else if (rd || ft)   st = 3'd7;
        else begin
            for (int k = 0; k < m_att; k++) begin
                if (k > 0 && n >= m_to[k-1] && n < m_crs[k]) st = 3'd6;
                if (n >= m_crs[k] && n < m_cfg[k])           st = 3'd3;
                if (n == m_cfg[k])                           st = 3'd4;
                if (n > m_cfg[k] && n < m_to[k])             st = 3'd5;
            end
        end
        return {st, pw, cr, co, cs, rd, ft};
    endfunction

    // Called #1 after an edge with RST_N low; releases reset and runs.
    task automatic run_seq(input int done_at, input int glitch_at, input int extra,
                           input int abort_at, input int lock_at);
        int end_n;
        build_model(2, done_at);
        end_n = term_edge() + extra;
        rst_n = 1'b1;
        for (int n = 0; n <= end_n; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("out@%0d", n), {23'd0, outs}, {23'd0, model_out(n)});
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_rst", {23'd0, outs}, {23'd0, RESET_VAL});
                cfg_done = 1'b0;
                return;
            end
            if (lock_at >= 0) begin
                if (n == lock_at) locked = 1'b0;
                else if (n == lock_at + 1) locked = 1'b1;
                else if (n == lock_at + 2) begin
                    build_model(n + 1, done_at);
                    end_n = term_edge() + extra;
                end
            end
            cfg_done = ((done_at >= 0) && (n >= done_at)) || (n == glitch_at);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        cfg_done = 1'b0;
        locked   = 1'b1;
        #1;
        check("rst_async", {23'd0, outs}, {23'd0, RESET_VAL});
        @(posedge clk);
        #1;
        check("rst_hold", {23'd0, outs}, {23'd0, RESET_VAL});
    endtask

    initial begin
        int done_at, glitch_at, abort_at;
        clk_run  = 1'b0;
        rst_n    = 1'b1;
        cfg_done = 1'b0;
        locked   = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_noclk", {23'd0, outs}, {23'd0, RESET_VAL});
        clk_run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk", {23'd0, outs}, {23'd0, RESET_VAL});

        // Success: CFG_DONE raised after edge 30, ready at edge 31.
        run_seq(30, -1, 20, -1, -1);
        do_reset();
        // Two timeouts -> fault, held for 1000 clocks.
        run_seq(-1, -1, 1000, -1, -1);
        do_reset();
        // CFG_DONE on the exact first timeout edge.
        run_seq(38, -1, 20, -1, -1);
        do_reset();
        // CFG_DONE on the exact final timeout edge.
        run_seq(71, -1, 20, -1, -1);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            done_at   = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 80));
            glitch_at = int'($urandom_range(2 + STAB, 2 + STAB + PWDN - 2));
            run_seq(done_at, glitch_at, int'($urandom_range(5, 30)), -1, -1);
            do_reset();
        end

        // Mid-sequence reset, then a complete sequence from S_SYNC.
        for (int i = 0; i < 3; i++) begin
            abort_at = int'($urandom_range(0, 70));
            run_seq(-1, -1, 10, abort_at, -1);
            @(posedge clk);
            #1;
            check("abort_hold", {23'd0, outs}, {23'd0, RESET_VAL});
            run_seq(int'($urandom_range(20, 60)), -1, 10, -1, -1);
            do_reset();
        end

`ifdef RSTSEQ_LOCK_MON_EN
        // One-clock lock loss while in S_DONE, then the full sequence again.
        run_seq(30, -1, 20, -1, 40);
        do_reset();
        // Lock loss in the fault terminal.
        run_seq(-1, -1, 20, -1, 80);
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
